// File: rtl/encoder_16x4_queue.sv
// Sequential 16-to-4 priority encoder: pending requests are served highest index first over valid/ready.
// Optional served-handshake counter port is enabled by defining SERVED_CNT_EN.
module encoder_16x4_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] req_in,
    input  logic        ready_out,
    output logic [3:0]  code,
    output logic        valid,
    output logic        any_pending
`ifdef SERVED_CNT_EN
    ,
    output logic [7:0]  served_cnt
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENCODE  = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_pending;
    logic [15:0] w_pending_next;
    logic [15:0] w_clear_mask;
    logic [15:0] w_load_mask;
    logic [3:0]  r_code;
    logic        r_valid;
    logic [3:0]  w_top_idx;
    logic        w_accept;

    assign w_accept    = (r_state == ST_PRESENT) && ready_out;
    assign w_load_mask = load ? req_in : 16'h0000;

    // Only the presented bit is cleared; a same-cycle reload of it wins via the OR below.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_clear
            assign w_clear_mask[gi] = w_accept && (r_code == 4'(gi));
        end
    endgenerate

    assign w_pending_next = (r_pending & ~w_clear_mask) | w_load_mask;

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        w_top_idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_pending[i]) begin
                w_top_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pending_next != 16'h0000) begin
                    w_state_next = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                w_state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (ready_out) begin
                    w_state_next = (w_pending_next != 16'h0000) ? ST_ENCODE : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 16'h0000;
            r_code    <= 4'h0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (r_state == ST_ENCODE) begin
                r_code  <= w_top_idx;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SERVED_CNT_EN
    logic [7:0] r_served_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_served_cnt <= 8'h00;
        end else if (w_accept) begin
            r_served_cnt <= r_served_cnt + 8'h01;
        end
    end

    assign served_cnt = r_served_cnt;
`endif

    assign code        = r_code;
    assign valid       = r_valid;
    assign any_pending = |r_pending;

endmodule

// File: tb/tb_encoder_16x4_queue.sv
// Self-checking bench for encoder_16x4_queue: transaction model plus directed vectors.
// Define SERVED_CNT_EN for both files to also check the handshake counter.
module tb_encoder_16x4_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] req_in;
    logic        ready_out;
    logic [3:0]  code;
    logic        valid;
    logic        any_pending;
`ifdef SERVED_CNT_EN
    logic [7:0]  served_cnt;
`endif

    always #5 clk = ~clk;

    encoder_16x4_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .req_in      (req_in),
        .ready_out   (ready_out),
        .code        (code),
        .valid       (valid),
        .any_pending (any_pending)
`ifdef SERVED_CNT_EN
        ,
        .served_cnt  (served_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic logic [3:0] highest(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return 4'(i);
        end
        return 4'h0;
    endfunction

    function automatic logic [15:0] decode4x16(input logic [3:0] c);
        logic [15:0] d;
        d = 16'h0000;
        d[c] = 1'b1;
        return d;
    endfunction

    // Model: a set of pending requests; every served code is preceded by one
    // selection cycle that picks the highest request present before that edge.
    logic [15:0] m_pend  = 16'h0000;
    logic [3:0]  m_code  = 4'h0;
    bit          m_valid = 1'b0;
    bit          m_prep  = 1'b0;
    logic [7:0]  m_cnt   = 8'h00;

    always @(posedge clk) begin : model
        logic [15:0] nxt;
        cyc++;
        if (!rst_n) begin
            m_pend  = 16'h0000;
            m_code  = 4'h0;
            m_valid = 1'b0;
            m_prep  = 1'b0;
            m_cnt   = 8'h00;
        end else begin
            nxt = m_pend;
            if (m_valid && ready_out) begin
                nxt[m_code] = 1'b0;
                m_cnt       = m_cnt + 8'h01;
                m_valid     = 1'b0;
            end
            if (load) nxt = nxt | req_in;
            if (m_prep) begin
                m_code  = highest(m_pend);
                m_valid = 1'b1;
                m_prep  = 1'b0;
            end else if (!m_valid && nxt != 16'h0000) begin
                m_prep = 1'b1;
            end
            m_pend = nxt;
        end
    end

    // Compare on the falling edge; inputs only change 2 ns after a rising edge.
    bit         p_valid = 1'b0;
    bit         p_ready = 1'b0;
    bit         p_rst   = 1'b0;
    logic [3:0] p_code  = 4'h0;
    int         hs_code[$];
    int         hs_cyc[$];

    always @(negedge clk) begin
        check("valid", int'(valid), int'(m_valid));
        check("any_pending", int'(any_pending), int'(m_pend != 16'h0000));
        if (m_valid) check("code", int'(code), int'(m_code));
`ifdef SERVED_CNT_EN
        check("served_cnt", int'(served_cnt), int'(m_cnt));
`endif
        if (p_rst && p_valid && !p_ready) begin
            check("hold_valid", int'(valid), 1);
            check("hold_code", int'(code), int'(p_code));
        end
        if (rst_n && valid && ready_out) begin
            hs_code.push_back(int'(code));
            hs_cyc.push_back(cyc);
        end
        p_valid = valid;
        p_ready = ready_out;
        p_rst   = rst_n;
        p_code  = code;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!valid && n < lim) begin
            tick();
            n++;
        end
        if (!valid) timeout("wait_valid");
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((valid || any_pending) && n < lim) begin
            tick();
            n++;
        end
        if (valid || any_pending) timeout("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_drain[4] = '{15, 10, 5, 0};
`ifdef SERVED_CNT_EN
        int cnt0;
`endif

        // Reset with inputs active: they must be ignored.
        rst_n = 1'b0; load = 1'b1; req_in = 16'hFFFF; ready_out = 1'b0;
        tick(); tick();
        check("rst_code", int'(code), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_any_pending", int'(any_pending), 0);
`ifdef SERVED_CNT_EN
        check("rst_served_cnt", int'(served_cnt), 0);
`endif
        rst_n = 1'b1; load = 1'b0; req_in = 16'h0000;
        tick();

        // Single request: valid two edges after the load edge.
        load = 1'b1; req_in = 16'h0001;
        tick();
        load = 1'b0;
        check("single_not_yet", int'(valid), 0);
        tick();
        check("single_valid", int'(valid), 1);
        check("single_code", int'(code), 0);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        check("single_done_valid", int'(valid), 0);
        check("single_done_pending", int'(any_pending), 0);

        // Drain order with ready held high.
        hs_code.delete(); hs_cyc.delete();
`ifdef SERVED_CNT_EN
        cnt0 = int'(served_cnt);
`endif
        load = 1'b1; req_in = 16'h8421; ready_out = 1'b1;
        tick();
        load = 1'b0;
        wait_idle(40);
        ready_out = 1'b0;
        check("drain_count", hs_code.size(), 4);
        for (int k = 0; k < 4 && k < hs_code.size(); k++) begin
            check($sformatf("drain_code%0d", k), hs_code[k], exp_drain[k]);
            if (k > 0) check($sformatf("drain_gap%0d", k), hs_cyc[k] - hs_cyc[k-1], 2);
        end
`ifdef SERVED_CNT_EN
        check("drain_served_cnt", int'(served_cnt) - cnt0, 4);
`endif

        // Backpressure: code held for 5 cycles, then the next one.
        load = 1'b1; req_in = 16'h0030;
        tick();
        load = 1'b0;
        wait_valid(10);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", int'(valid), 1);
            check("bp_code", int'(code), 5);
            tick();
        end
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        wait_valid(10);
        check("bp_next_code", int'(code), 4);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        wait_idle(10);

        // Simultaneous accept and reload of the presented bit.
        load = 1'b1; req_in = 16'h0030;
        tick();
        load = 1'b0;
        wait_valid(10);
        check("reload_first", int'(code), 5);
        load = 1'b1; req_in = 16'h0020; ready_out = 1'b1;
        tick();
        load = 1'b0; ready_out = 1'b0;
        check("reload_pending", int'(any_pending), 1);
        wait_valid(10);
        check("reload_again", int'(code), 5);
        ready_out = 1'b1;
        wait_idle(20);
        ready_out = 1'b0;

        // All 16 bits drain in 32 edges after the load edge.
        load = 1'b1; req_in = 16'hFFFF; ready_out = 1'b1;
        tick();
        load = 1'b0;
        repeat (31) tick();
        check("all_last_valid", int'(valid), 1);
        check("all_last_code", int'(code), 0);
        tick();
        check("all_done_valid", int'(valid), 0);
        check("all_done_pending", int'(any_pending), 0);
        ready_out = 1'b0;

        // Decoder sweep: decoding the code reproduces the one-hot request.
        for (int i = 0; i < 16; i++) begin
            load = 1'b1; req_in = 16'h0001 << i;
            tick();
            load = 1'b0;
            wait_valid(10);
            check($sformatf("sweep_decode%0d", i), int'(decode4x16(code)), int'(16'h0001 << i));
            ready_out = 1'b1;
            tick();
            ready_out = 1'b0;
        end

        // Reset while presenting discards the in-flight code.
        load = 1'b1; req_in = 16'h00F0;
        tick();
        load = 1'b0;
        wait_valid(10);
        check("midrst_presenting", int'(code), 7);
        rst_n = 1'b0; ready_out = 1'b1;
        tick();
        check("midrst_valid", int'(valid), 0);
        check("midrst_pending", int'(any_pending), 0);
        check("midrst_code", int'(code), 0);
        rst_n = 1'b1; ready_out = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_16x4_queue.md
# encoder_16x4_queue

Sequential 16-to-4 priority encoder that accepts a 16-bit request vector and returns the index of each set bit as a 4-bit code, one at a time, over a valid/ready handshake. It is the inverse of the lab's 4x16 decoder: decoding each emitted code reproduces the one-hot line for that request. Requests accumulate in a pending register. Codes are served highest-index first until the register is empty.

## Interface
Parameters:
- none; widths fixed at 16 request lines and 4 code bits.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- load  input  1  capture strobe; when high, req_in is ORed into pending.
- req_in  input  16  request vector; bit i requests code i.
- ready_out  input  1  consumer accepts the presented code.
- code  output  4  index of the presented request.
- valid  output  1  code is valid.
- any_pending  output  1  reduction-OR of the pending register.
- served_cnt  output  8  handshake counter; present only with SERVED_CNT_EN.

## Operation
- One clock; reset is synchronous and active-low.
- Reset values: pending=16'h0000, code=4'h0, valid=0, any_pending=0, served_cnt=8'h00, state=IDLE.
- Priority: the highest set index wins. For example, pending 16'h8421 yields 15, 10, 5, 0 in that order.
- IDLE: valid=0.
  - If load=1 and req_in≠0, pending is set to req_in and the state moves to ENCODE.
  - If load=1 and req_in=0, nothing changes.
- ENCODE:
  - code is set to the highest set index of the current pending register value.
  - valid is set to 1 and the state moves to PRESENT.
  - Any load in this cycle ORs into pending. New bits are considered at the next ENCODE, not this one.
- PRESENT: valid=1, and code is held stable until accepted.
  - When ready_out=1 at an edge, the handshake completes:
    - pending bit[code] is cleared;
    - valid goes to 0;
    - served_cnt increments;
    - the state moves to ENCODE if the updated pending is nonzero, otherwise to IDLE.
  - When ready_out=0, nothing changes except any load OR-in.
- Pending update on each edge: pending_next = (pending & ~clear_mask) | (load ? req_in : 0).
  - A bit cleared by acceptance and reloaded in the same cycle stays set, so the new request is preserved.
- any_pending is combinational from the pending register.

## Timing
- Latency from a load edge in IDLE to valid=1 is 2 edges: the load edge, then the ENCODE edge.
- Maximum throughput is one code every 2 cycles, since ENCODE sits between consecutive PRESENT states.
- Requirements while valid=1:
  - code must not change;
  - valid must not drop without ready_out=1.
- Boundary cases:
  - Bit 0 alone yields code 0, valid=1. Code 0 is distinguished from idle only by valid.
  - All 16 bits set drains in 32 cycles with ready_out held high.
  - served_cnt wraps from 255 to 0.
- Reset mid-operation (rst_n=0 at any edge):
  - all registers return to reset values;
  - load and ready_out are ignored during that edge;
  - any in-flight code is discarded.

## Configuration
- SERVED_CNT_EN defined: the 8-bit served_cnt port and its register exist. The counter increments on each completed handshake and resets to 0.
- SERVED_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 edges with load=1 and req_in=16'hFFFF. Expect code=0, valid=0, any_pending=0, served_cnt=0.
- Single request: load 16'h0001 for one cycle. Expect valid=1 with code=0 two edges later. Then ready_out=1 gives valid=0, IDLE, any_pending=0.
- Drain order: load 16'h8421 with ready_out held high. Expect codes 15, 10, 5, 0 on valid pulses 2 cycles apart, and served_cnt=4.
- Backpressure: load 16'h0030 and hold ready_out=0 for 5 cycles. Expect code=5 and valid=1 stable throughout. Release ready_out, then expect code=4.
- Simultaneous reload: while code=5 is presented, assert load with 16'h0020 and ready_out=1 in the same cycle. Expect bit 5 to remain pending and code=5 presented again next.
- Decoder sweep and mid-operation reset:
  - For i=0..15, load a one-hot request with bit i set. Expect code=i; feeding code to decoder_4x16 gives output_D equal to the same one-hot value.
  - Assert rst_n=0 while in PRESENT. Expect valid=0 and pending=0 on the next edge.
